l2_pmem_burst_responder: RTL and testbench
==========================================

Name: l2_pmem_burst_responder

Overview:
- Memory-side responder for the L2 cache controller's pmem line interface.
- Accepts one 256-bit line read or write request, held until the response: pmem_read/pmem_write in, pmem_resp out.
- Converts each request into a 4-beat x 64-bit burst transaction on the physical-memory port.
- Sits between the L2 cache datapath/control and main memory (or the arbiter in front of it).

Parameters:
- LINE_W, 256, cache line width in bits
- BEAT_W, 64, burst beat width in bits
- BEATS, 4, beats per line (LINE_W/BEAT_W)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- line_address  in  32  line request address from the L2; bits [4:0] ignored
- line_read  in  1  line read request, held high until line_resp
- line_write  in  1  line write request, held high until line_resp
- line_wdata  in  256  line to write; stable while line_write is high
- line_rdata  out  256  assembled read line; valid when line_resp is high
- line_resp  out  1  one-cycle completion pulse
- burst_address  out  32  {latched_addr[31:5], 5'b0}
- burst_read  out  1  burst read command
- burst_write  out  1  burst write command
- burst_wdata  out  64  current write beat
- burst_rdata  in  64  incoming read beat
- burst_resp  in  1  beat handshake from memory

Behaviour:
- Reset values:
  - All outputs 0; line_rdata 0.
  - Beat counter 0; state IDLE.
  - Reset is async, so it takes effect mid-burst: the current transaction is abandoned and no line_resp is issued.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - line_write high: latch address and line_wdata, go to WR_BURST.
  - Otherwise line_read high: latch address, go to RD_BURST.
  - Write has priority when both are high. The read stays pending and is served after DONE returns to IDLE.
- RD_BURST:
  - burst_read is held high.
  - Each cycle with burst_resp=1 stores burst_rdata into line_rdata[64*cnt +: 64] and increments cnt.
  - When cnt=3 and burst_resp=1, go to DONE and clear cnt. burst_read drops in the same cycle DONE is entered.
- WR_BURST:
  - burst_write is held high; burst_wdata = latched_line[64*cnt +: 64].
  - Each burst_resp=1 advances cnt.
  - When cnt=3 and burst_resp=1, go to DONE.
- DONE: line_resp=1 for exactly one cycle, then IDLE.
- Beat order is ascending; beat 0 is the lowest 64 bits. Beats need not be consecutive: cycles with burst_resp=0 stall without losing data.
- Latency: best case BEATS+1 cycles from the accept edge to line_resp high.
- line_rdata holds its value after DONE until the next read burst begins overwriting it.
- burst_resp is ignored in IDLE/DONE.
- The counter is 2 bits and wraps 3->0 on the last beat.

Optional Feature:
- Macro: L2_PMEM_LINE_BUFFER_EN.
- With the macro defined, the block keeps a one-entry buffer: valid bit, tag = address[31:5], and the last line read or written.
  - A line_read in IDLE whose address tag matches a valid buffer skips the burst and goes straight to DONE. line_rdata is the buffered line; latency is 1 cycle.
  - A write loads the buffer with line_wdata and its tag.
  - Reset clears valid.
- Without the macro, every request bursts and no buffer storage exists.

Decomposition:
- Package l2_pmem_types holds:
  - state enum burst_state_t
  - localparams LINE_W, BEAT_W, BEATS
  - function line_align(addr) returning {addr[31:5], 5'b0}
- One sub-module, l2_burst_beat_counter: 2-bit counter with clear/enable and a last-beat flag, reused for the read and write paths.

Test Plan:
- Read, no stalls: line_address=0x0000_1234, memory beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  -> burst_address=0x0000_1220; line_resp exactly 5 cycles after accept.
  -> line_rdata={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write with stalls: line_wdata=256'h0123...CDEF, burst_resp pattern 1,0,0,1,1,0,1.
  -> burst_wdata steps through beats 0..3 only on resp cycles.
  -> burst_write drops after beat 3; exactly one line_resp.
- Simultaneous line_read and line_write at address 0x80.
  -> the write burst completes first (line_resp #1), then the read burst runs (line_resp #2); no overlap of burst_read/burst_write.
- Async reset asserted after 2 read beats.
  -> all outputs 0 immediately; no line_resp.
  -> a new read after reset gathers all 4 fresh beats.
- L2_PMEM_LINE_BUFFER_EN: write line X to 0x100, then read 0x100.
  -> the read gets line_resp 1 cycle after accept, with burst_read never asserted and line_rdata=X.
  -> a read of 0x120 performs a full burst.
- Back-to-back reads: line_read held high across a line_resp.
  -> a second full burst starts the cycle after DONE; no beat is dropped or duplicated.

Source files
------------

// File: rtl/l2_pmem_burst_responder_pkg.sv
// l2_pmem_types: shared state type, geometry and address helper for the L2 pmem burst responder.
package l2_pmem_types;
   localparam int LINE_W = 256;
   localparam int BEAT_W = 64;
   localparam int BEATS  = LINE_W / BEAT_W;
   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} burst_state_t;
   function automatic logic [31:0] line_align(input logic [31:0] addr);
      return addr & ~32'h1f;
   endfunction
endpackage

// File: rtl/l2_pmem_burst_responder_beat_counter.sv
// l2_burst_beat_counter: 2-bit beat index with clear/enable and a last-beat flag; wraps after the final beat.
module l2_burst_beat_counter
   import l2_pmem_types::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_clr,
   input  logic       i_en,
   output logic [1:0] o_cnt,
   output logic       o_last
);
   logic [1:0] r_cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_cnt <= '0;
      else     r_cnt <= i_clr ? 2'd0 : i_en ? r_cnt + 2'd1 : r_cnt;
   assign o_cnt  = r_cnt;
   assign o_last = r_cnt == 2'(BEATS - 1);
endmodule

// File: rtl/l2_pmem_burst_responder.sv
// l2_pmem_burst_responder: turns 256-bit L2 line requests into 4 x 64-bit memory bursts.
// Define L2_PMEM_LINE_BUFFER_EN to add a one-line buffer that serves repeat reads without a burst.
module l2_pmem_burst_responder
   import l2_pmem_types::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       line_address,
   input  logic              line_read,
   input  logic              line_write,
   input  logic [LINE_W-1:0] line_wdata,
   output logic [LINE_W-1:0] line_rdata,
   output logic              line_resp,
   output logic [31:0]       burst_address,
   output logic              burst_read,
   output logic              burst_write,
   output logic [BEAT_W-1:0] burst_wdata,
   input  logic [BEAT_W-1:0] burst_rdata,
   input  logic              burst_resp
);
   burst_state_t      r_state;
   logic [31:0]       r_addr;
   logic [LINE_W-1:0] r_line;
   logic [LINE_W-1:0] r_rdata;
   logic              r_resp;
   logic              r_rd;
   logic              r_wr;
   logic [1:0]        w_cnt;
   logic              w_last;
   logic              w_active;
   logic [LINE_W-1:0] w_rd_next;
   assign w_active = r_state == RD_BURST || r_state == WR_BURST;
   l2_burst_beat_counter u_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (!w_active),
      .i_en   (w_active && burst_resp),
      .o_cnt  (w_cnt),
      .o_last (w_last)
   );
   always_comb begin
      w_rd_next = r_rdata;
      w_rd_next[BEAT_W*w_cnt +: BEAT_W] = burst_rdata;
   end
`ifdef L2_PMEM_LINE_BUFFER_EN
   logic              r_buf_vld;
   logic [26:0]       r_buf_tag;
   logic [LINE_W-1:0] r_buf_line;
   logic              w_hit;
   assign w_hit = r_buf_vld && r_buf_tag == line_address[31:5];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_buf_vld  <= 1'b0;
         r_buf_tag  <= '0;
         r_buf_line <= '0;
      end else if (r_state == IDLE && line_write) begin
         r_buf_vld  <= 1'b1;
         r_buf_tag  <= line_address[31:5];
         r_buf_line <= line_wdata;
      end else if (r_state == RD_BURST && burst_resp && w_last) begin
         r_buf_vld  <= 1'b1;
         r_buf_tag  <= r_addr[31:5];
         r_buf_line <= w_rd_next;
      end
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_line  <= '0;
         r_rdata <= '0;
         r_resp  <= 1'b0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
      end else begin
         r_resp <= 1'b0;
         case (r_state)
            IDLE:
               // write wins; a concurrent read stays pending until the next IDLE
               if (line_write) begin
                  r_addr  <= line_align(line_address);
                  r_line  <= line_wdata;
                  r_wr    <= 1'b1;
                  r_state <= WR_BURST;
               end else if (line_read) begin
                  r_addr <= line_align(line_address);
`ifdef L2_PMEM_LINE_BUFFER_EN
                  if (w_hit) begin
                     r_rdata <= r_buf_line;
                     r_resp  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_rd    <= 1'b1;
                     r_state <= RD_BURST;
                  end
`else
                  r_rd    <= 1'b1;
                  r_state <= RD_BURST;
`endif
               end
            RD_BURST:
               if (burst_resp) begin
                  r_rdata <= w_rd_next;
                  if (w_last) begin
                     r_rd    <= 1'b0;
                     r_resp  <= 1'b1;
                     r_state <= DONE;
                  end
               end
            WR_BURST:
               if (burst_resp && w_last) begin
                  r_wr    <= 1'b0;
                  r_resp  <= 1'b1;
                  r_state <= DONE;
               end
            default: r_state <= IDLE;
         endcase
      end
   assign line_rdata    = r_rdata;
   assign line_resp     = r_resp;
   assign burst_address = r_addr;
   assign burst_read    = r_rd;
   assign burst_write   = r_wr;
   assign burst_wdata   = r_wr ? r_line[BEAT_W*w_cnt +: BEAT_W] : '0;
endmodule

// File: tb/tb_l2_pmem_burst_responder.sv
// tb_l2_pmem_burst_responder: directed scenarios for the L2 pmem burst responder.
module tb_l2_pmem_burst_responder;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  line_address = '0;
   logic         line_read = 1'b0;
   logic         line_write = 1'b0;
   logic [255:0] line_wdata = '0;
   logic [255:0] line_rdata;
   logic         line_resp;
   logic [31:0]  burst_address;
   logic         burst_read;
   logic         burst_write;
   logic [63:0]  burst_wdata;
   logic [63:0]  burst_rdata = '0;
   logic         burst_resp = 1'b0;
   int errors = 0;
   int checks = 0;

   l2_pmem_burst_responder dut (
      .clk           (clk),
      .rst           (rst),
      .line_address  (line_address),
      .line_read     (line_read),
      .line_write    (line_write),
      .line_wdata    (line_wdata),
      .line_rdata    (line_rdata),
      .line_resp     (line_resp),
      .burst_address (burst_address),
      .burst_read    (burst_read),
      .burst_write   (burst_write),
      .burst_wdata   (burst_wdata),
      .burst_rdata   (burst_rdata),
      .burst_resp    (burst_resp)
   );

   always #5 clk = ~clk;

   // memory model: answers the active burst per pat (LSB first, 1 after bit 15) until line_resp or a 60-edge budget
   task automatic serve(input logic [255:0] mem, input logic [15:0] pat, output int edges, output int beats,
                        output int badw, output logic saw_rd, output logic ovl, output logic [31:0] baddr);
      int p = 0;
      edges = 0; beats = 0; badw = 0; saw_rd = 1'b0; ovl = 1'b0; baddr = '0;
      for (int c = 0; c < 60; c++) begin
         burst_resp = 1'b0;
         if (burst_read || burst_write) begin
            if (p == 0) baddr = burst_address;
            burst_resp = (p < 16) ? pat[p] : 1'b1;
            p++;
            if (burst_read) saw_rd = 1'b1;
            if (burst_read && burst_write) ovl = 1'b1;
            if (burst_write && burst_wdata !== mem[64*(beats%4) +: 64]) badw++;
            burst_rdata = mem[64*(beats%4) +: 64];
            if (burst_resp) beats++;
         end
         @(posedge clk); #1;
         edges++;
         if (line_resp) break;
      end
      burst_resp = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (line_resp !== 1'b0) begin errors++; $display("FAIL reset_resp got=%b exp=0", line_resp); end
      checks++; if ({burst_read, burst_write} !== 2'b00) begin errors++; $display("FAIL reset_cmd got=%b exp=00", {burst_read, burst_write}); end
      checks++; if (line_rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", line_rdata); end
      checks++; if ({burst_address, burst_wdata} !== '0) begin errors++; $display("FAIL reset_addr_wdata got=%h/%h exp=0", burst_address, burst_wdata); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_read_nostall();
      logic [255:0] m = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
      int e, b, w; logic sr, ov; logic [31:0] ba;
      line_address = 32'h0000_1234; line_read = 1'b1;
      serve(m, 16'hffff, e, b, w, sr, ov, ba);
      line_read = 1'b0;
      checks++; if (ba !== 32'h0000_1220) begin errors++; $display("FAIL read_addr got=%h exp=00001220", ba); end
      checks++; if (e !== 5) begin errors++; $display("FAIL read_latency got=%0d exp=5", e); end
      checks++; if (line_rdata !== m) begin errors++; $display("FAIL read_data got=%h exp=%h", line_rdata, m); end
      checks++; if (burst_read !== 1'b0) begin errors++; $display("FAIL read_drop got=%b exp=0", burst_read); end
      @(posedge clk); #1;
      checks++; if (line_resp !== 1'b0) begin errors++; $display("FAIL read_resp_pulse got=%b exp=0", line_resp); end
   endtask

   task automatic test_write_stall();
      logic [255:0] wd = 256'h0123456789ABCDEF_F0E1D2C3B4A59687_1357924680ACEBDF_02468ACE1357CDEF;
      int e, b, w; logic sr, ov; logic [31:0] ba;
      line_address = 32'h0000_0300; line_wdata = wd; line_write = 1'b1;
      serve(wd, 16'h0059, e, b, w, sr, ov, ba);
      line_write = 1'b0;
      checks++; if (w !== 0) begin errors++; $display("FAIL write_beats_bad got=%0d exp=0", w); end
      checks++; if (b !== 4 || e !== 8) begin errors++; $display("FAIL write_timing got beats=%0d edges=%0d exp 4/8", b, e); end
      checks++; if (ba !== 32'h0000_0300 || sr !== 1'b0) begin errors++; $display("FAIL write_addr got=%h rd=%b exp=00000300/0", ba, sr); end
      checks++; if (burst_write !== 1'b0) begin errors++; $display("FAIL write_drop got=%b exp=0", burst_write); end
      @(posedge clk); #1;
      checks++; if (line_resp !== 1'b0) begin errors++; $display("FAIL write_single_resp got=%b exp=0", line_resp); end
   endtask

   task automatic test_simultaneous();
      logic [255:0] wd = {64'hAAAA_0003, 64'hAAAA_0002, 64'hAAAA_0001, 64'hAAAA_0000};
      logic [255:0] m  = {64'hBBBB_0003, 64'hBBBB_0002, 64'hBBBB_0001, 64'hBBBB_0000};
      int e, b, w; logic sr, ov; logic [31:0] ba;
      line_address = 32'h0000_0080; line_wdata = wd; line_write = 1'b1; line_read = 1'b1;
      serve(wd, 16'hffff, e, b, w, sr, ov, ba);
      line_write = 1'b0;
      checks++; if (e !== 5 || w !== 0 || sr !== 1'b0) begin errors++; $display("FAIL simul_write got edges=%0d bad=%0d rd=%b exp 5/0/0", e, w, sr); end
      serve(m, 16'hffff, e, b, w, sr, ov, ba);
      line_read = 1'b0;
`ifdef L2_PMEM_LINE_BUFFER_EN
      checks++; if (e !== 2 || sr !== 1'b0) begin errors++; $display("FAIL simul_read_hit got edges=%0d rd=%b exp 2/0", e, sr); end
      checks++; if (line_rdata !== wd) begin errors++; $display("FAIL simul_read_data got=%h exp=%h", line_rdata, wd); end
`else
      checks++; if (e !== 6 || sr !== 1'b1) begin errors++; $display("FAIL simul_read got edges=%0d rd=%b exp 6/1", e, sr); end
      checks++; if (line_rdata !== m) begin errors++; $display("FAIL simul_read_data got=%h exp=%h", line_rdata, m); end
`endif
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL simul_overlap got=%b exp=0", ov); end
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      logic [255:0] m = {64'hC3C3, 64'hC2C2, 64'hC1C1, 64'hC0C0};
      int e, b, w; logic sr, ov; logic [31:0] ba;
      line_address = 32'h0000_0040; line_read = 1'b1;
      @(posedge clk); #1;
      burst_resp = 1'b1; burst_rdata = 64'hDEAD_0000;
      @(posedge clk); #1;
      burst_rdata = 64'hDEAD_0001;
      @(posedge clk); #1;
      burst_resp = 1'b0; rst = 1'b1; line_read = 1'b0;
      #1;
      checks++; if ({line_resp, burst_read, burst_write} !== 3'b000) begin errors++; $display("FAIL areset_ctl got=%b exp=000", {line_resp, burst_read, burst_write}); end
      checks++; if (line_rdata !== '0 || burst_address !== '0) begin errors++; $display("FAIL areset_data got=%h/%h exp=0", line_rdata, burst_address); end
      @(posedge clk); #1;
      checks++; if (line_resp !== 1'b0) begin errors++; $display("FAIL areset_noresp got=%b exp=0", line_resp); end
      rst = 1'b0;
      @(posedge clk); #1;
      line_read = 1'b1;
      serve(m, 16'hffff, e, b, w, sr, ov, ba);
      line_read = 1'b0;
      checks++; if (e !== 5 || line_rdata !== m) begin errors++; $display("FAIL areset_reread got edges=%0d data=%h exp 5/%h", e, line_rdata, m); end
      @(posedge clk); #1;
   endtask

   task automatic test_line_buffer();
      logic [255:0] x = {64'h5A5A_0003, 64'h5A5A_0002, 64'h5A5A_0001, 64'h5A5A_0000};
      logic [255:0] m = {64'h7E7E_0003, 64'h7E7E_0002, 64'h7E7E_0001, 64'h7E7E_0000};
      logic [255:0] n = {64'h6D6D_0003, 64'h6D6D_0002, 64'h6D6D_0001, 64'h6D6D_0000};
      int e, b, w; logic sr, ov; logic [31:0] ba;
      line_address = 32'h0000_0100; line_wdata = x; line_write = 1'b1;
      serve(x, 16'hffff, e, b, w, sr, ov, ba);
      line_write = 1'b0;
      @(posedge clk); #1;
      line_read = 1'b1;
      serve(m, 16'hffff, e, b, w, sr, ov, ba);
      line_read = 1'b0;
`ifdef L2_PMEM_LINE_BUFFER_EN
      checks++; if (e !== 1 || sr !== 1'b0) begin errors++; $display("FAIL buf_hit got edges=%0d rd=%b exp 1/0", e, sr); end
      checks++; if (line_rdata !== x) begin errors++; $display("FAIL buf_hit_data got=%h exp=%h", line_rdata, x); end
`else
      checks++; if (e !== 5 || sr !== 1'b1) begin errors++; $display("FAIL nobuf_read got edges=%0d rd=%b exp 5/1", e, sr); end
      checks++; if (line_rdata !== m) begin errors++; $display("FAIL nobuf_read_data got=%h exp=%h", line_rdata, m); end
`endif
      @(posedge clk); #1;
      line_address = 32'h0000_0120; line_read = 1'b1;
      serve(n, 16'hffff, e, b, w, sr, ov, ba);
      line_read = 1'b0;
      checks++; if (e !== 5 || sr !== 1'b1 || line_rdata !== n) begin errors++; $display("FAIL buf_miss got edges=%0d rd=%b data=%h exp 5/1/%h", e, sr, line_rdata, n); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [255:0] m0 = {64'h1111_0003, 64'h1111_0002, 64'h1111_0001, 64'h1111_0000};
      logic [255:0] m1 = {64'h2222_0003, 64'h2222_0002, 64'h2222_0001, 64'h2222_0000};
      int e, b, w; logic sr, ov; logic [31:0] ba;
      line_address = 32'h0000_0200; line_read = 1'b1;
      serve(m0, 16'hffff, e, b, w, sr, ov, ba);
      checks++; if (e !== 5 || line_rdata !== m0) begin errors++; $display("FAIL b2b_first got edges=%0d data=%h exp 5/%h", e, line_rdata, m0); end
      line_address = 32'h0000_0240;
      serve(m1, 16'hffff, e, b, w, sr, ov, ba);
      line_read = 1'b0;
      checks++; if (e !== 6 || b !== 4) begin errors++; $display("FAIL b2b_second got edges=%0d beats=%0d exp 6/4", e, b); end
      checks++; if (line_rdata !== m1 || ba !== 32'h0000_0240) begin errors++; $display("FAIL b2b_data got=%h addr=%h exp=%h/00000240", line_rdata, ba, m1); end
      @(posedge clk); #1;
      burst_resp = 1'b1; burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      repeat (3) @(posedge clk);
      #1;
      burst_resp = 1'b0;
      checks++; if (line_rdata !== m1 || {line_resp, burst_read} !== 2'b00) begin errors++; $display("FAIL idle_resp_ignored got=%h ctl=%b exp=%h/00", line_rdata, {line_resp, burst_read}, m1); end
   endtask

   initial begin
      test_reset();
      test_read_nostall();
      test_write_stall();
      test_simultaneous();
      test_async_reset();
      test_line_buffer();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
